// File: rtl/scurve_sweep_ctrl_if.sv
// Handshake and data signals between the S-curve sweep sequencer, its slow-control
// loader, the single-channel test block and the readout FIFO.
interface scurve_sweep_ctrl_if;
  logic        sweep_start;
  logic        sweep_stop;
  logic        single_chn_mode;
  logic [5:0]  single_chn_sel;
  logic [9:0]  dac_start;
  logic [9:0]  dac_end;
  logic [9:0]  dac_step;
  logic        cfg_load;
  logic [5:0]  cfg_chn;
  logic [9:0]  cfg_dac;
  logic        cfg_done;
  logic        scurve_test_start;
  logic        one_channel_done;
  logic [15:0] scurve_data_in;
  logic        scurve_data_wr_en_in;
  logic        fifo_prog_full;
  logic [15:0] out_data;
  logic        out_wr_en;
  logic        sweep_busy;
  logic        sweep_done;
  logic        sweep_aborted;

  modport master (
    input  sweep_start, sweep_stop, single_chn_mode, single_chn_sel,
           dac_start, dac_end, dac_step, cfg_done, one_channel_done,
           scurve_data_in, scurve_data_wr_en_in, fifo_prog_full,
    output cfg_load, cfg_chn, cfg_dac, scurve_test_start, out_data, out_wr_en,
           sweep_busy, sweep_done, sweep_aborted
  );

  modport slave (
    output sweep_start, sweep_stop, single_chn_mode, single_chn_sel,
           dac_start, dac_end, dac_step, cfg_done, one_channel_done,
           scurve_data_in, scurve_data_wr_en_in, fifo_prog_full,
    input  cfg_load, cfg_chn, cfg_dac, scurve_test_start, out_data, out_wr_en,
           sweep_busy, sweep_done, sweep_aborted
  );
endinterface

// File: rtl/scurve_sweep_ctrl.sv
// Steps channel/DAC-threshold points: reload slow control, settle, emit a point header,
// run one single-channel test and pass its result words through to the readout FIFO.
module scurve_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4000
) (
  input logic                 Clk,
  input logic                 reset_n,
  scurve_sweep_ctrl_if.master bus
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [3:0] {
    StIdle, StCfgLoad, StCfgWait, StSettle, StWaitRoom,
    StHeader, StStart, StWaitDone, StNext, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      chn_q, chn_d;
  logic [9:0]      dac_q, dac_d;
  logic [9:0]      dac_start_q, dac_start_d;
  logic [9:0]      dac_end_q, dac_end_d;
  logic [9:0]      dac_step_q, dac_step_d;
  logic            single_q, single_d;
  logic            stop_q, stop_d;
  logic            aborted_q, aborted_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      cfg_chn_q;
  logic [9:0]      cfg_dac_q;
  logic [15:0]     data_q;
  logic            wr_q;
  logic [10:0]     dac_next;
  logic            stop_req;

  always_comb begin
    state_d     = state_q;
    chn_d       = chn_q;
    dac_d       = dac_q;
    dac_start_d = dac_start_q;
    dac_end_d   = dac_end_q;
    dac_step_d  = dac_step_q;
    single_d    = single_q;
    stop_d      = stop_q;
    aborted_d   = aborted_q;
    cnt_d       = cnt_q;
    stop_req    = stop_q | bus.sweep_stop;
    dac_next    = {1'b0, dac_q} + {1'b0, dac_step_q};

    if (state_q != StIdle && bus.sweep_stop) stop_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (bus.sweep_start) begin
          dac_start_d = bus.dac_start;
          dac_end_d   = bus.dac_end;
          dac_step_d  = (bus.dac_step == 10'd0) ? 10'd1 : bus.dac_step;
          single_d    = bus.single_chn_mode;
          chn_d       = bus.single_chn_mode ? bus.single_chn_sel : 6'd0;
          dac_d       = bus.dac_start;
          stop_d      = 1'b0;
          aborted_d   = 1'b0;
          state_d     = StCfgLoad;
        end
      end
      StCfgLoad: state_d = stop_req ? StDone : StCfgWait;
      StCfgWait: begin
        cnt_d = '0;
        if (stop_req)          state_d = StDone;
        else if (bus.cfg_done) state_d = StSettle;
      end
      StSettle: begin
        if (stop_req)                                    state_d = StDone;
        else if (cnt_q == CntW'(SETTLE_CYCLES - 1))      state_d = StWaitRoom;
        else                                             cnt_d = cnt_q + CntW'(1);
      end
      StWaitRoom: begin
        if (stop_req)                 state_d = StDone;
        else if (!bus.fifo_prog_full) state_d = StHeader;
      end
      StHeader:   state_d = stop_req ? StDone : StStart;
      StStart:    state_d = StWaitDone;
      StWaitDone: if (bus.one_channel_done) state_d = StNext;
      StNext: begin
        if (stop_req) begin
          state_d = StDone;
        end else if (dac_next > {1'b0, dac_end_q} || dac_next[10]) begin
          // DAC range exhausted for this channel: rewind and move to the next channel.
          dac_d = dac_start_q;
          if (single_q || chn_q == 6'd63) begin
            state_d = StDone;
          end else begin
            chn_d   = chn_q + 6'd1;
            state_d = StCfgLoad;
          end
        end else begin
          dac_d   = dac_next[9:0];
          state_d = StCfgLoad;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d == StDone && state_q != StDone && stop_req) aborted_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      chn_q       <= '0;
      dac_q       <= '0;
      dac_start_q <= '0;
      dac_end_q   <= '0;
      dac_step_q  <= '0;
      single_q    <= 1'b0;
      stop_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cnt_q       <= '0;
      cfg_chn_q   <= '0;
      cfg_dac_q   <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      chn_q       <= chn_d;
      dac_q       <= dac_d;
      dac_start_q <= dac_start_d;
      dac_end_q   <= dac_end_d;
      dac_step_q  <= dac_step_d;
      single_q    <= single_d;
      stop_q      <= stop_d;
      aborted_q   <= aborted_d;
      cnt_q       <= cnt_d;
      data_q      <= bus.scurve_data_in;
      wr_q        <= bus.scurve_data_wr_en_in;
      // Hold the loaded point stable from one cfg_load to the next.
      if (state_d == StCfgLoad) begin
        cfg_chn_q <= chn_d;
        cfg_dac_q <= dac_d;
      end
    end
  end

  assign bus.cfg_load          = (state_q == StCfgLoad);
  assign bus.cfg_chn           = cfg_chn_q;
  assign bus.cfg_dac           = cfg_dac_q;
  assign bus.scurve_test_start = (state_q == StStart);
  assign bus.out_wr_en         = wr_q | (state_q == StHeader);
  assign bus.out_data          = (state_q == StHeader) ? {chn_q, dac_q} : data_q;
  assign bus.sweep_busy        = (state_q != StIdle);
  assign bus.sweep_done        = (state_q == StDone);
  assign bus.sweep_aborted     = aborted_q;

endmodule

// File: tb/tb_scurve_sweep_ctrl.sv
// Randomized scoreboard bench for scurve_sweep_ctrl with a behavioural loader/test model.
module tb_scurve_sweep_ctrl;
  localparam int S = 6;

  logic Clk = 1'b0;
  logic reset_n;
  scurve_sweep_ctrl_if bus ();

  scurve_sweep_ctrl #(.SETTLE_CYCLES(S)) dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic fifo_at_edge = 1'b0;
  always @(posedge Clk) fifo_at_edge <= bus.fifo_prog_full;

  logic [15:0] exp_cfg[$];
  logic [16:0] exp_out[$];   // bit 16 marks a header word
  bit          exp_done[$];
  logic [15:0] pdata[$];     // six result words per started test, in start order

  // Event bookkeeping: writer bumps *_seq, monitor consumes via *_seen.
  int start_cyc, start_seq = 0, start_seen = 0;
  int stop_cyc, stop_seq = 0, stop_seen = 0;
  int rel_cyc, rel_seq = 0, rel_seen = 0;
  int done_cyc, cfgd_seq = 0, cfgd_seen = 0;
  int ocd_cyc, ocd_seq = 0, ocd_seen = 0;
  bit lat_en = 1'b1;
  int last_hdr_cyc = -100;
  int n_cfg = 0, n_starts = 0, n_done = 0;
  int ld_cnt = 0, t_phase = 0, t_wait = 0, t_word = 0, t_idx = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor, slow-control loader model and single-channel test model.
  always @(negedge Clk) begin
    logic [16:0] e;
    bus.cfg_done             = 1'b0;
    bus.one_channel_done     = 1'b0;
    bus.scurve_data_wr_en_in = 1'b0;
    bus.scurve_data_in       = 16'h0;
    if (!reset_n) begin
      ld_cnt  = 0;
      t_phase = 0;
    end else begin
      if (bus.cfg_load) begin
        n_cfg++;
        chk("cfg_pending", exp_cfg.size() > 0, 1);
        if (exp_cfg.size() > 0) chk("cfg_point", {bus.cfg_chn, bus.cfg_dac}, exp_cfg.pop_front());
        chk("busy_at_cfg", bus.sweep_busy, 1);
        if (start_seq != start_seen) begin
          chk("start_to_cfg_load", cyc - start_cyc, 1);
          start_seen = start_seq;
        end
        if (ocd_seq != ocd_seen) begin
          chk("done_to_cfg_load", cyc - ocd_cyc, 2);
          ocd_seen = ocd_seq;
        end
        cfgd_seen = cfgd_seq;
      end
      if (bus.out_wr_en) begin
        chk("out_pending", exp_out.size() > 0, 1);
        if (exp_out.size() > 0) begin
          e = exp_out.pop_front();
          chk(e[16] ? "header_word" : "data_word", bus.out_data, e[15:0]);
          if (e[16]) begin
            chk("room_before_header", fifo_at_edge, 0);
            last_hdr_cyc = cyc;
            if (rel_seq != rel_seen) begin
              chk("header_after_release", cyc - rel_cyc, 1);
              rel_seen = rel_seq;
            end
          end
        end
      end
      if (bus.scurve_test_start) begin
        n_starts++;
        chk("header_to_start", cyc - last_hdr_cyc, 1);
        if (lat_en && cfgd_seq != cfgd_seen) chk("cfg_done_to_start", cyc - done_cyc, S + 3);
        cfgd_seen = cfgd_seq;
      end
      if (bus.sweep_done) begin
        n_done++;
        chk("done_pending", exp_done.size() > 0, 1);
        if (exp_done.size() > 0) chk("sweep_aborted", bus.sweep_aborted, exp_done.pop_front());
        if (ocd_seq != ocd_seen) begin
          chk("done_to_sweep_done", cyc - ocd_cyc, 2);
          ocd_seen = ocd_seq;
        end
        if (stop_seq != stop_seen) begin
          chk("stop_to_done", cyc - stop_cyc, 1);
          stop_seen = stop_seq;
        end
      end
      // loader: answers each cfg_load after 1..3 cycles
      if (ld_cnt > 0) begin
        ld_cnt--;
        if (ld_cnt == 0) begin
          bus.cfg_done = 1'b1;
          done_cyc     = cyc;
          cfgd_seq++;
        end
      end
      if (bus.cfg_load) ld_cnt = $urandom_range(1, 3);
      // test block: short delay, six words with random gaps, then one_channel_done
      if (bus.scurve_test_start) begin
        chk("one_test_outstanding", t_phase, 0);
        t_phase = 1;
        t_wait  = $urandom_range(1, 3);
        t_word  = 0;
      end else begin
        case (t_phase)
          1: begin
            t_wait--;
            if (t_wait == 0) t_phase = 2;
          end
          2: if ($urandom_range(0, 3) != 0) begin
            bus.scurve_data_in       = pdata[t_idx * 6 + t_word];
            bus.scurve_data_wr_en_in = 1'b1;
            t_word++;
            if (t_word == 6) t_phase = 3;
          end
          3: begin
            bus.one_channel_done = 1'b1;
            ocd_cyc = cyc;
            ocd_seq++;
            t_idx++;
            t_phase = 0;
          end
          default: ;
        endcase
      end
    end
  end

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ctl"}, {bus.cfg_load, bus.scurve_test_start, bus.out_wr_en, bus.sweep_busy,
                       bus.sweep_done, bus.sweep_aborted}, 0);
    chk({nm, "_data"}, bus.out_data, 0);
    chk({nm, "_cfg"}, {bus.cfg_chn, bus.cfg_dac}, 0);
  endtask

  // kind: 0 normal, 1 stop in WAIT_DONE of point cut, 2 stop in SETTLE of point cut,
  // 3 reset in SETTLE of point cut. hold: fifo_prog_full held on the first point.
  task automatic run_sweep(input bit mode, input int sel, input int ds, input int de,
                           input int st, input int cut, input int kind, input bit hold);
    logic [15:0] plist[$];
    int stp, c, d, n, ncfg, nstart, cnt, guard, done_base;
    logic [15:0] w;
    stp = (st == 0) ? 1 : st;
    c = mode ? sel : 0;
    forever begin
      d = ds;
      forever begin
        plist.push_back({c[5:0], d[9:0]});
        n = d + stp;
        if (n > de || n > 1023) break;
        d = n;
      end
      if (mode || c == 63) break;
      c++;
    end
    ncfg   = (kind == 0) ? plist.size() : cut + 1;
    nstart = (kind == 0 || kind == 1) ? ncfg : cut;
    for (int i = 0; i < ncfg; i++) exp_cfg.push_back(plist[i]);
    for (int i = 0; i < nstart; i++) begin
      exp_out.push_back({1'b1, plist[i]});
      for (int k = 0; k < 6; k++) begin
        w = 16'($urandom);
        pdata.push_back(w);
        exp_out.push_back({1'b0, w});
      end
    end
    if (kind != 3) exp_done.push_back(kind != 0);
    lat_en    = !hold;
    done_base = n_done;

    @(negedge Clk);
    bus.single_chn_mode = mode;
    bus.single_chn_sel  = 6'(sel);
    bus.dac_start       = 10'(ds);
    bus.dac_end         = 10'(de);
    bus.dac_step        = 10'(st);
    bus.sweep_start     = 1'b1;
    start_cyc = cyc;
    start_seq++;
    @(negedge Clk);
    bus.sweep_start     = 1'b0;
    // range inputs change after the start pulse; the sweep must keep its latched copy
    bus.single_chn_mode = 1'($urandom);
    bus.single_chn_sel  = 6'($urandom);
    bus.dac_start       = 10'($urandom);
    bus.dac_end         = 10'($urandom);
    bus.dac_step        = 10'($urandom);

    if (hold) begin
      bus.fifo_prog_full = 1'b1;
      repeat (S + 110) @(negedge Clk);
      bus.fifo_prog_full = 1'b0;
      rel_cyc = cyc;
      rel_seq++;
    end
    if (kind != 0) begin
      cnt = 0;
      guard = 0;
      forever begin
        if ((kind == 1) ? bus.scurve_test_start : bus.cfg_load) cnt++;
        if (cnt == cut + 1 || guard > 20000) break;
        @(negedge Clk);
        guard++;
      end
      if (kind == 1) begin
        @(negedge Clk);
        bus.sweep_stop = 1'b1;
        @(negedge Clk);
        bus.sweep_stop = 1'b0;
      end else begin
        repeat (4) @(negedge Clk);
        if (kind == 2) begin
          bus.sweep_stop = 1'b1;
          stop_cyc = cyc;
          stop_seq++;
          @(negedge Clk);
          bus.sweep_stop = 1'b0;
        end else begin
          #2 reset_n = 1'b0;
          #1 chk_reset_outputs("async_reset");
          chk("reset_cfg_left", exp_cfg.size(), 0);
          chk("reset_out_left", exp_out.size(), 0);
          repeat (3) @(negedge Clk);
          reset_n = 1'b1;
          chk("reset_no_done", n_done - done_base, 0);
          exp_cfg.delete();
          exp_out.delete();
          return;
        end
      end
    end
    for (int i = 0; i < 20000 && n_done == done_base; i++) @(negedge Clk);
    repeat (3) @(negedge Clk);
    chk("sweep_done_count", n_done - done_base, 1);
    chk("cfg_left", exp_cfg.size(), 0);
    chk("out_left", exp_out.size(), 0);
    chk("done_left", exp_done.size(), 0);
    chk("idle_ctl", {bus.cfg_load, bus.scurve_test_start, bus.out_wr_en, bus.sweep_busy,
                     bus.sweep_done}, 0);
    chk("idle_aborted", bus.sweep_aborted, kind != 0);
    exp_cfg.delete();
    exp_out.delete();
    exp_done.delete();
  endtask

  initial begin
    int ds, de, st, md;
    reset_n             = 1'b0;
    bus.sweep_start     = 1'b0;
    bus.sweep_stop      = 1'b0;
    bus.single_chn_mode = 1'b0;
    bus.single_chn_sel  = 6'd0;
    bus.dac_start       = 10'd0;
    bus.dac_end         = 10'd0;
    bus.dac_step        = 10'd0;
    bus.fifo_prog_full  = 1'b0;
    #3 chk_reset_outputs("reset");
    repeat (3) @(negedge Clk);
    reset_n = 1'b1;

    run_sweep(1, 5, 100, 102, 1, 0, 0, 0);
    run_sweep(1, 17, 1000, 1023, 10, 0, 0, 0);
    run_sweep(1, 17, 50, 40, 3, 0, 0, 0);
    run_sweep(0, 9, 0, 0, 1, 0, 0, 0);
    run_sweep(1, 9, 200, 203, 0, 0, 0, 1);
    run_sweep(1, 3, 10, 14, 1, 1, 1, 0);
    run_sweep(1, 3, 10, 14, 1, 1, 2, 0);
    run_sweep(1, 7, 300, 305, 1, 2, 3, 0);
    run_sweep(1, 7, 300, 305, 1, 0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      md = ($urandom_range(0, 4) == 0) ? 0 : 1;
      ds = $urandom_range(0, 1023);
      st = $urandom_range(0, 7);
      if (md == 0)                         de = ($urandom_range(0, 1) == 0) ? ds : ds - 1;
      else if ($urandom_range(0, 3) == 0)  de = ds - $urandom_range(1, 20);
      else                                 de = ds + $urandom_range(0, 30);
      if (de > 1023) de = 1023;
      if (de < 0) de = 0;
      run_sweep(md[0], $urandom_range(0, 63), ds, de, st, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
